// File: rtl/ibex_csr_cmd_encoder.sv
// Debug-side CSR access initiator: turns an abstract CSR command into the
// short RV32I instruction stream (LUI/ADDI staging, CSR op, EBREAK) run from the program buffer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready_o=1
// LUI   | presenting LUI ScratchReg, hi
// ADDI  | presenting ADDI ScratchReg, src, lo
// CSR   | presenting the CSRRW/CSRRS/CSRRC instruction
// EBRK  | presenting EBREAK, always the last word when present
module ibex_csr_cmd_encoder #(
    parameter logic [4:0] ScratchReg = 5'd8,
    parameter logic [4:0] DataReg    = 5'd9,
    parameter bit         EmitEbreak = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [11:0] cmd_csr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_last_o,
    input  logic        abort_i,
    output logic        err_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LUI  = 3'd1;
    localparam logic [2:0] S_ADDI = 3'd2;
    localparam logic [2:0] S_CSR  = 3'd3;
    localparam logic [2:0] S_EBRK = 3'd4;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q;
    logic [11:0] csr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        handshake;
    logic [1:0]  op_s;
    logic [11:0] csr_s;
    logic [31:0] wdata_s;
    logic [19:0] hi_s;
    logic [11:0] lo_s;
    logic        has_lui;
    logic        has_addi;
    logic        ro_write;
    logic [4:0]  addi_src;
    logic [4:0]  csr_rs1;
    logic [4:0]  csr_rd;
    logic [2:0]  funct3;
    logic [31:0] word_d;
    logic        last_d;

    assign accept    = cmd_ready_o & cmd_valid_i & ~abort_i;
    assign handshake = instr_valid_o & instr_ready_i;

    // Word generation looks at the incoming command during acceptance so the
    // first word can be registered in the same edge that captures the command.
    assign op_s    = accept ? cmd_op_i    : op_q;
    assign csr_s   = accept ? cmd_csr_i   : csr_q;
    assign wdata_s = accept ? cmd_wdata_i : wdata_q;

    // ADDI sign-extends lo, so bit 11 borrows from the upper part.
    assign hi_s     = wdata_s[31:12] + {19'd0, wdata_s[11]};
    assign lo_s     = wdata_s[11:0];
    assign has_lui  = (hi_s != 20'd0);
    assign has_addi = (lo_s != 12'd0);
    assign ro_write = (op_s != OP_READ) && (csr_s[11:10] == 2'b11);
    assign addi_src = has_lui ? ScratchReg : 5'd0;

    always_comb begin
        csr_rs1 = 5'd0;
        csr_rd  = 5'd0;
        funct3  = 3'b010;
        if (op_s == OP_READ) begin
            csr_rd = DataReg;
        end else begin
            csr_rs1 = (wdata_s != 32'd0) ? ScratchReg : 5'd0;
            if (op_s == OP_WRITE) begin
                funct3 = 3'b001;
            end else if (op_s == OP_CLEAR) begin
                funct3 = 3'b011;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (ro_write) begin
                            state_d = EmitEbreak ? S_EBRK : S_IDLE;
                        end else if (op_s == OP_READ) begin
                            state_d = S_CSR;
                        end else if (has_lui) begin
                            state_d = S_LUI;
                        end else if (has_addi) begin
                            state_d = S_ADDI;
                        end else begin
                            state_d = S_CSR;
                        end
                    end
                end
                S_LUI: if (handshake) state_d = has_addi ? S_ADDI : S_CSR;
                S_ADDI: if (handshake) state_d = S_CSR;
                S_CSR: if (handshake) state_d = EmitEbreak ? S_EBRK : S_IDLE;
                S_EBRK: if (handshake) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        word_d = 32'd0;
        case (state_d)
            S_LUI:  word_d = {hi_s, ScratchReg, 7'h37};
            S_ADDI: word_d = {lo_s, addi_src, 3'b000, ScratchReg, 7'h13};
            S_CSR:  word_d = {csr_s, csr_rs1, funct3, csr_rd, 7'h73};
            S_EBRK: word_d = EBREAK;
            default: word_d = 32'd0;
        endcase
        last_d = (state_d == S_EBRK) || ((state_d == S_CSR) && !EmitEbreak);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            op_q          <= OP_READ;
            csr_q         <= 12'd0;
            wdata_q       <= 32'd0;
            cmd_ready_o   <= 1'b1;
            instr_valid_o <= 1'b0;
            instr_rdata_o <= 32'd0;
            instr_last_o  <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= cmd_op_i;
                csr_q   <= cmd_csr_i;
                wdata_q <= cmd_wdata_i;
            end
            cmd_ready_o   <= (state_d == S_IDLE);
            instr_valid_o <= (state_d != S_IDLE);
            instr_rdata_o <= word_d;
            instr_last_o  <= last_d;
            err_o         <= accept && ro_write;
        end
    end

endmodule
